// File: rtl/conv1d_kernel_sequencer_if.sv
// Bus bundle for conv1d_kernel_sequencer: weight writes, sample stream,
// MAC array drive/return and result stream.
interface conv1d_kernel_sequencer_if;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;

  logic          wr_en;
  logic          wr_ready;
  logic [1:0]    wr_kernel;
  logic [3:0]    wr_idx;
  logic [DW-1:0] wr_data;

  logic          x_valid;
  logic          x_ready;
  logic [DW-1:0] x_data;
  logic          x_last;

  logic          mac_clear;
  logic          mac_valid;
  logic [DW-1:0] mac_x;
  logic [DW-1:0] mac_w_1, mac_w_2, mac_w_3, mac_w_4;
  logic [AW-1:0] mac_out_1, mac_out_2, mac_out_3, mac_out_4;

  logic          y_valid;
  logic          y_ready;
  logic          y_last;
  logic [AW-1:0] y_1, y_2, y_3, y_4;

  modport slave (
    input  wr_en, wr_kernel, wr_idx, wr_data,
    input  x_valid, x_data, x_last,
    input  mac_out_1, mac_out_2, mac_out_3, mac_out_4,
    input  y_ready,
    output wr_ready, x_ready,
    output mac_clear, mac_valid, mac_x, mac_w_1, mac_w_2, mac_w_3, mac_w_4,
    output y_valid, y_last, y_1, y_2, y_3, y_4
  );

  modport master (
    output wr_en, wr_kernel, wr_idx, wr_data,
    output x_valid, x_data, x_last,
    output mac_out_1, mac_out_2, mac_out_3, mac_out_4,
    output y_ready,
    input  wr_ready, x_ready,
    input  mac_clear, mac_valid, mac_x, mac_w_1, mac_w_2, mac_w_3, mac_w_4,
    input  y_valid, y_last, y_1, y_2, y_3, y_4
  );
endinterface

// File: rtl/conv1d_kernel_sequencer.sv
// Sequencer for a 4-MAC 1-D convolution array: holds kernels and a sliding window,
// drives clear + KLEN beats per window. Define CONV_RELU_EN to clamp results at zero.
module conv1d_kernel_sequencer #(
  parameter int unsigned KLEN    = 3,
  parameter int unsigned MAC_LAT = 1
) (
  input logic clk,
  input logic rst,
  conv1d_kernel_sequencer_if.slave bus
);
  localparam int unsigned IW = $clog2(KLEN);
  localparam int unsigned CW = $clog2(KLEN + 1);
  localparam int unsigned DCW = 3;

  typedef enum logic [2:0] {FILL, CLEAR, ISSUE, DRAIN, OUTPUT} state_t;

  state_t            state;
  logic signed [7:0] kern [4][KLEN];
  logic signed [7:0] win [KLEN];
  logic [CW-1:0]     count;
  logic [IW-1:0]     k;
  logic [DCW-1:0]    dcnt;
  logic              frame_end;
  logic [7:0]        w_q [4];
  logic [15:0]       y_q [4];

  assign bus.mac_w_1 = w_q[0];
  assign bus.mac_w_2 = w_q[1];
  assign bus.mac_w_3 = w_q[2];
  assign bus.mac_w_4 = w_q[3];
  assign bus.y_1     = y_q[0];
  assign bus.y_2     = y_q[1];
  assign bus.y_3     = y_q[2];
  assign bus.y_4     = y_q[3];

  function automatic logic [15:0] post(input logic [15:0] v);
`ifdef CONV_RELU_EN
    post = v[15] ? 16'h0000 : v;
`else
    post = v;
`endif
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FILL;
      count         <= '0;
      k             <= '0;
      dcnt          <= '0;
      frame_end     <= 1'b0;
      bus.wr_ready  <= 1'b1;
      bus.x_ready   <= 1'b1;
      bus.mac_clear <= 1'b0;
      bus.mac_valid <= 1'b0;
      bus.mac_x     <= '0;
      bus.y_valid   <= 1'b0;
      bus.y_last    <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        w_q[n] <= '0;
        y_q[n] <= '0;
        for (int t = 0; t < KLEN; t++) kern[n][t] <= '0;
      end
      for (int t = 0; t < KLEN; t++) win[t] <= '0;
    end else begin
      case (state)
        FILL: begin
          // writes are only accepted here, so weights never move under a window
          if (bus.wr_en && bus.wr_ready && (32'(bus.wr_idx) < KLEN))
            kern[bus.wr_kernel][IW'(bus.wr_idx)] <= bus.wr_data;
          if (bus.x_valid && bus.x_ready) begin
            for (int t = 0; t < KLEN - 1; t++) win[t] <= win[t+1];
            win[KLEN-1] <= bus.x_data;
            frame_end   <= bus.x_last;
            if (count == CW'(KLEN - 1)) begin
              count         <= CW'(KLEN);
              state         <= CLEAR;
              bus.x_ready   <= 1'b0;
              bus.wr_ready  <= 1'b0;
              bus.mac_clear <= 1'b1;
            end else if (bus.x_last) begin
              count <= '0;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        CLEAR: begin
          bus.mac_clear <= 1'b0;
          bus.mac_valid <= 1'b1;
          bus.mac_x     <= win[0];
          for (int n = 0; n < 4; n++) w_q[n] <= kern[n][0];
          k     <= '0;
          state <= ISSUE;
        end
        ISSUE: begin
          if (k == IW'(KLEN - 1)) begin
            bus.mac_valid <= 1'b0;
            bus.mac_x     <= '0;
            for (int n = 0; n < 4; n++) w_q[n] <= '0;
            dcnt  <= '0;
            state <= DRAIN;
          end else begin
            k         <= k + IW'(1);
            bus.mac_x <= win[k + IW'(1)];
            for (int n = 0; n < 4; n++) w_q[n] <= kern[n][k + IW'(1)];
          end
        end
        DRAIN: begin
          // mac_out is stable by the end of the last drain cycle
          if (dcnt == DCW'(MAC_LAT - 1)) begin
            y_q[0]      <= post(bus.mac_out_1);
            y_q[1]      <= post(bus.mac_out_2);
            y_q[2]      <= post(bus.mac_out_3);
            y_q[3]      <= post(bus.mac_out_4);
            bus.y_last  <= frame_end;
            bus.y_valid <= 1'b1;
            state       <= OUTPUT;
          end else begin
            dcnt <= dcnt + DCW'(1);
          end
        end
        OUTPUT: begin
          if (bus.y_ready) begin
            bus.y_valid  <= 1'b0;
            count        <= frame_end ? '0 : CW'(KLEN - 1);
            bus.x_ready  <= 1'b1;
            bus.wr_ready <= 1'b1;
            state        <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: doc/conv1d_kernel_sequencer.md
Name: conv1d_kernel_sequencer

Overview:
- Upstream/downstream controller for the 4-MAC 1-D convolution array. Serves four kernels, shared input stream, one result set per window.
- Holds four KLEN-tap 8-bit kernels and a KLEN-deep sliding window of input samples.
- For each window: drives one clear pulse plus KLEN valid beats into the four MAC units, waits MAC_LAT cycles, then captures the four 16-bit sums and presents them on a valid/ready output.
- Valid-mode convolution, no padding: a frame of N samples yields N-KLEN+1 result sets.

Parameters:
- KLEN, 3, kernel length in taps; legal range 2..16.
- MAC_LAT, 1, cycles from the last mac_valid beat until mac_out_n is stable; legal range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  kernel weight write strobe.
- wr_ready  out  1  high when kernel writes are accepted.
- wr_kernel  in  2  target kernel, 0..3.
- wr_idx  in  4  tap index, 0..KLEN-1.
- wr_data  in  8  signed weight.
- x_valid  in  1  input sample valid.
- x_ready  out  1  input sample ready.
- x_data  in  8  signed input sample.
- x_last  in  1  marks the last sample of a frame.
- mac_clear  out  1  to the MAC array clear input.
- mac_valid  out  1  to the MAC array valid input.
- mac_x  out  8  signed sample; fans out to all four MAC x inputs.
- mac_w_1..mac_w_4  out  8 each  signed weight for MAC n.
- mac_out_1..mac_out_4  in  16 each  signed MAC accumulator outputs.
- y_valid  out  1  result set valid.
- y_ready  in  1  result set ready.
- y_last  out  1  marks the last result of a frame.
- y_1..y_4  out  16 each  signed convolution results.

Behaviour:
- **Reset.** State FILL, window count 0, all weights 0. All outputs 0 except x_ready=1 and wr_ready=1. Reset mid-operation abandons the window and any pending result; y_valid is low the cycle after rst.
- **State FILL.** x_ready=1 and wr_ready=1.
  - A write completes when wr_en=1 and wr_ready=1; it stores kernel[wr_kernel][wr_idx]. wr_idx>=KLEN is ignored.
  - wr_en outside FILL is dropped. Weights are therefore stable during computation.
  - A sample is accepted when x_valid && x_ready. The window shifts (window[0] is the oldest), count increments, and the frame-end flag is set to x_last.
  - When count reaches KLEN, go to CLEAR.
  - If x_last is accepted with count<KLEN after increment, the frame is too short: count=0, no result, stay in FILL.
  - A write and a sample in the same cycle are both accepted.
- **State CLEAR.** One cycle with mac_clear=1 and mac_valid=0; go to ISSUE with k=0.
- **State ISSUE.** KLEN cycles.
  - mac_valid=1, mac_x=window[k], mac_w_n=kernel[n-1][k]; k increments each cycle.
  - After k=KLEN-1, go to DRAIN.
  - mac_clear and mac_valid are never high together.
- **State DRAIN.** MAC_LAT cycles with mac_valid=0. At the end of the last DRAIN cycle, register y_n<=mac_out_n, set y_last from the frame-end flag, and go to OUTPUT.
- **State OUTPUT.**
  - y_valid=1; y_n and y_last are held stable until y_ready.
  - On handshake: if frame-end, set count=0; else set count=KLEN-1 (slide by one). Go to FILL.
- **Latency.** The sample completing a window is accepted in cycle t; y_valid rises in cycle t+KLEN+MAC_LAT+2.
- **Widths and arithmetic.** Results are the MAC's 16-bit two's-complement sums, wrap-around, with no saturation in this block.
- **Outputs outside their states.** mac_x and mac_w_n are 0 outside ISSUE.

Optional Feature:
- Macro: CONV_RELU_EN.
- Defined: each y_n captured in DRAIN is max(mac_out_n, 0); a negative value yields 0x0000. This adds no latency.
- Undefined: y_n is mac_out_n unmodified.

Test Plan:
1. Frame with two windows. KLEN=3; kernel0={1,2,3}, kernel1={-1,0,1}; stream x=1,2,3,4 with x_last on 4, y_ready=1. Required: y_1=14, y_2=2, y_last=0; then y_1=20, y_2=2, y_last=1. y_valid rises exactly 6 cycles after accepting sample 3 (MAC_LAT=1).
2. Wrap-around. kernel2={-128,-128,-128}, x=-128 three times with x_last. Required: y_3=0xC000 (-16384, wrapped from 49152). With CONV_RELU_EN defined: y_3=0. With it undefined: y_1 and y_3 pass negatives unmodified.
3. Output backpressure and stalls. y_ready=0 for 10 cycles in OUTPUT. Required: y_n stable, x_ready=0, wr_en writes dropped (weights unchanged). x_valid gaps in FILL only delay the result.
4. Short frame. Frame of 2 samples with x_last on the second. Required: no y_valid, no mac_clear, count returns to 0. The next 3-sample frame produces exactly one result with y_last=1.
5. MAC drive sequence. Check mac_clear is a 1-cycle pulse followed by exactly KLEN mac_valid beats carrying window order oldest-first; wr_idx=5 is ignored.
6. Reset mid-ISSUE. Assert rst in the second ISSUE cycle. Required: next cycle mac_valid=0, y_valid=0, x_ready=1, weights=0; a fresh frame then computes as if from cold start.
